ic_output_checker: RTL and testbench

- Response-side counterpart of the IC tester's stimulus generator.
- Samples all 14 GPIO pins of the socketed logic IC while the stimulus generator sweeps input vectors.
- For every gate, computes the expected output from the sampled input pins and compares it with the sampled output pin.
- Reports pass/fail per gate, once every gate has seen every input combination or a timeout expires.

---
 rtl/ic_tester_pkg.sv | 45 ++++
 rtl/gpio_sync.sv | 28 ++
 rtl/ic_output_checker.sv | 196 +++++++++++++++++++
 tb/tb_ic_output_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_tester_pkg.sv
// Shared IC tester definitions: type codes, socket pinouts,
// checker FSM encoding and per-type gate counts.
package ic_tester_pkg;

  localparam logic [3:0] T_NAND = 4'd0;
  localparam logic [3:0] T_AND  = 4'd1;
  localparam logic [3:0] T_OR   = 4'd2;
  localparam logic [3:0] T_XOR  = 4'd3;
  localparam logic [3:0] T_XNOR = 4'd4;
  localparam logic [3:0] T_NOR  = 4'd5;
  localparam logic [3:0] T_NOT  = 4'd6;

  localparam int NPINS     = 14;
  localparam int MAX_GATES = 6;

  // Element [g] belongs to gate g; HI/LO form the 2-bit input value.
  localparam logic [3:0][3:0] PA_HI  = {4'd12, 4'd9, 4'd4, 4'd1};
  localparam logic [3:0][3:0] PA_LO  = {4'd11, 4'd8, 4'd3, 4'd0};
  localparam logic [3:0][3:0] PA_OUT = {4'd10, 4'd7, 4'd5, 4'd2};

  localparam logic [3:0][3:0] PB_HI  = {4'd11, 4'd8, 4'd5, 4'd2};
  localparam logic [3:0][3:0] PB_LO  = {4'd10, 4'd7, 4'd4, 4'd1};
  localparam logic [3:0][3:0] PB_OUT = {4'd12, 4'd9, 4'd3, 4'd0};

  localparam logic [5:0][3:0] PC_IN  =
    {4'd12, 4'd10, 4'd8, 4'd4, 4'd2, 4'd0};
  localparam logic [5:0][3:0] PC_OUT =
    {4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_EVAL,
    S_DONE
  } chk_state_t;

  function automatic logic [2:0] gate_count(input logic [3:0] code);
    logic [2:0] n;
    n = 3'd0;
    if (code <= T_NOR) n = 3'd4;
    else if (code == T_NOT) n = 3'd6;
    return n;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for the socket pins; every bit sees
// the same depth so each output word is one coherent snapshot.
module gpio_sync #(
  parameter int STAGES = 2,
  parameter int W      = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ic_output_checker.sv
// Response checker: compares sampled gate outputs with the logic
// function of the sampled inputs until full coverage or timeout.
module ic_output_checker
  import ic_tester_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  number,
  input  logic [13:0] gpio_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_mask,
  output logic        timeout,
  output logic        unsupported
);

  logic [13:0]      w_sync;
  logic             w_unused;
  logic [5:0][1:0]  w_in;
  logic [5:0]       w_obs;
  logic [5:0]       w_mis;
  logic [5:0][3:0]  w_req;
  logic [5:0][3:0]  w_hit;
  logic [5:0][3:0]  w_cov_nxt;
  logic [5:0]       w_fail_nxt;
  logic             w_cov_done;
  logic             w_last;

  chk_state_t       r_state;
  logic [3:0]       r_number;
  logic [6:0]       r_cnt;
  logic [5:0][3:0]  r_cov;
  logic [5:0]       r_fail;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_tout;
  logic             r_unsup;

  gpio_sync #(
    .STAGES (SYNC_STAGES),
    .W      (NPINS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gpio_in),
    .o_q   (w_sync)
  );

  // Pins 6 and 13 are supply pins on every supported part.
  assign w_unused = ^{w_sync[6], w_sync[13]};

  function automatic logic f_expect(
    input logic [3:0] code,
    input logic [1:0] v
  );
    logic e;
    case (code)
      T_NAND:  e = ~&v;
      T_AND:   e = &v;
      T_OR:    e = |v;
      T_XOR:   e = ^v;
      T_XNOR:  e = ~^v;
      T_NOR:   e = ~|v;
      T_NOT:   e = ~v[0];
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  always_comb begin
    w_in  = '0;
    w_obs = '0;
    w_req = '0;
    case (r_number)
      T_NAND, T_AND, T_OR, T_XOR, T_XNOR: begin
        for (int g = 0; g < 4; g++) begin
          w_in[g]  = {w_sync[PA_HI[g]], w_sync[PA_LO[g]]};
          w_obs[g] = w_sync[PA_OUT[g]];
          w_req[g] = 4'hF;
        end
      end
      T_NOR: begin
        for (int g = 0; g < 4; g++) begin
          w_in[g]  = {w_sync[PB_HI[g]], w_sync[PB_LO[g]]};
          w_obs[g] = w_sync[PB_OUT[g]];
          w_req[g] = 4'hF;
        end
      end
      T_NOT: begin
        for (int g = 0; g < 6; g++) begin
          w_in[g]  = {1'b0, w_sync[PC_IN[g]]};
          w_obs[g] = w_sync[PC_OUT[g]];
          w_req[g] = 4'h3;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mis = '0;
    w_hit = '0;
    for (int g = 0; g < MAX_GATES; g++) begin
      w_mis[g] = (|w_req[g]) &&
                 (w_obs[g] != f_expect(r_number, w_in[g]));
      w_hit[g] = w_req[g] & (4'b0001 << w_in[g]);
    end
  end

  assign w_cov_nxt  = r_cov | w_hit;
  assign w_fail_nxt = r_fail | w_mis;
  assign w_cov_done = ((w_cov_nxt & w_req) == w_req);
  assign w_last     = (r_cnt == 7'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_number <= '0;
      r_cnt    <= '0;
      r_cov    <= '0;
      r_fail   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_tout   <= 1'b0;
      r_unsup  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_number <= number;
            r_cnt    <= '0;
            r_cov    <= '0;
            r_fail   <= '0;
            r_pass   <= 1'b0;
            r_tout   <= 1'b0;
            r_busy   <= 1'b1;
            if (number > T_NOT) begin
              r_unsup <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_unsup <= 1'b0;
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (r_cnt == 7'(SKIP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_EVAL: begin
          r_fail <= w_fail_nxt;
          r_cov  <= w_cov_nxt;
          r_cnt  <= r_cnt + 7'd1;
          // Coverage wins over a timeout landing in the same cycle.
          if (w_cov_done) begin
            r_pass  <= ~|w_fail_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_last) begin
            r_tout  <= 1'b1;
            r_pass  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_mask   = r_fail;
  assign timeout     = r_tout;
  assign unsupported = r_unsup;

endmodule

// File: tb/tb_ic_output_checker.sv
// Randomized bench for ic_output_checker against a word-level
// model of gate truth tables, pinouts and coverage.
module tb_ic_output_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  number = '0;
  logic [13:0] gpio_in = '0;
  logic        busy, done, pass, timeout, unsupported;
  logic [5:0]  fail_mask;

  int n_chk = 0;
  int n_pass = 0;

  logic [13:0] wv [80];

  always #5 clk = ~clk;

  ic_output_checker #(
    .SYNC_STAGES (2),
    .SKIP_CYCLES (2),
    .TIMEOUT     (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .number      (number),
    .gpio_in     (gpio_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .timeout     (timeout),
    .unsupported (unsupported)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ngates(input int code);
    if (code <= 5) return 4;
    if (code == 6) return 6;
    return 0;
  endfunction

  function automatic int nvals(input int code);
    return (code == 6) ? 2 : 4;
  endfunction

  // b=1 selects the first-listed (high) input pin of a quad gate
  function automatic int pin_in(input int code, input int g, input int b);
    int ahi[4], alo[4], bhi[4], blo[4], c[6];
    ahi = '{1, 4, 9, 12};  alo = '{0, 3, 8, 11};
    bhi = '{2, 5, 8, 11};  blo = '{1, 4, 7, 10};
    c   = '{0, 2, 4, 8, 10, 12};
    if (code == 6) return c[g];
    if (code == 5) return b ? bhi[g] : blo[g];
    return b ? ahi[g] : alo[g];
  endfunction

  function automatic int pin_out(input int code, input int g);
    int a[4], b[4], c[6];
    a = '{2, 5, 7, 10};
    b = '{0, 3, 9, 12};
    c = '{1, 3, 5, 7, 9, 11};
    if (code == 6) return c[g];
    if (code == 5) return b[g];
    return a[g];
  endfunction

  function automatic bit gate_fn(input int code, input bit [1:0] v);
    case (code)
      0: return !(v[1] && v[0]);
      1: return v[1] && v[0];
      2: return v[1] || v[0];
      3: return v[1] ^ v[0];
      4: return !(v[1] ^ v[0]);
      5: return !(v[1] || v[0]);
      6: return !v[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [1:0] read_in(
    input int code, input int g, input logic [13:0] w
  );
    bit [1:0] v;
    if (code == 6) v = {1'b0, w[pin_in(code, g, 0)]};
    else v = {w[pin_in(code, g, 1)], w[pin_in(code, g, 0)]};
    return v;
  endfunction

  // mode 0 sweep, 1 random inputs, 2 held at 0, 3 raw noise
  task automatic make_stream(
    input int code, input int mode, input int spin, input bit sval
  );
    for (int i = 0; i < 80; i++) begin
      logic [13:0] w;
      bit [1:0] v;
      w = 14'($urandom);
      if (mode != 3) begin
        for (int g = 0; g < ngates(code); g++) begin
          case (mode)
            0: v = 2'(i % nvals(code));
            1: v = 2'($urandom_range(0, nvals(code) - 1));
            default: v = 2'b00;
          endcase
          if (code == 6) begin
            w[pin_in(code, g, 0)] = v[0];
          end else begin
            w[pin_in(code, g, 1)] = v[1];
            w[pin_in(code, g, 0)] = v[0];
          end
          w[pin_out(code, g)] = gate_fn(code, v);
        end
      end
      if (spin >= 0) w[spin] = sval;
      wv[i] = w;
    end
  endtask

  // Word k of the stream reaches the comparison 3 cycles after start
  task automatic model(
    input  int       code,
    output int       exp_c,
    output bit [5:0] exp_fm,
    output bit       exp_to,
    output bit       exp_pass,
    output bit       exp_uns
  );
    bit seen [6][4];
    exp_fm = '0; exp_to = 0; exp_uns = 0; exp_c = 0;
    if (code > 6) begin
      exp_uns = 1; exp_pass = 0;
      return;
    end
    for (int g = 0; g < 6; g++)
      for (int v = 0; v < 4; v++) seen[g][v] = 0;
    for (int k = 0; k < 64; k++) begin
      bit complete;
      for (int g = 0; g < ngates(code); g++) begin
        bit [1:0] v;
        v = read_in(code, g, wv[k]);
        if (wv[k][pin_out(code, g)] != gate_fn(code, v)) exp_fm[g] = 1;
        seen[g][v] = 1;
      end
      complete = 1;
      for (int g = 0; g < ngates(code); g++)
        for (int v = 0; v < nvals(code); v++)
          if (!seen[g][v]) complete = 0;
      if (complete) begin
        exp_c = k + 3;
        break;
      end
      if (k == 63) begin
        exp_c = 66;
        exp_to = 1;
      end
    end
    exp_pass = (exp_fm == 0) && !exp_to;
  endtask

  task automatic run_check(input int code, input bit noisy);
    int exp_c, got_c, c;
    bit [5:0] exp_fm;
    bit exp_to, exp_pass, exp_uns;
    model(code, exp_c, exp_fm, exp_to, exp_pass, exp_uns);
    @(negedge clk);
    number = 4'(code);
    start = 1'b1;
    gpio_in = 14'($urandom);
    @(posedge clk);
    c = 0;
    got_c = -1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      number = 4'($urandom);
      if (c == 0) check("busy_after_start", busy, 1);
      if (done) begin
        got_c = c;
        break;
      end
      if (c >= 100) break;
      gpio_in = (c < 80) ? wv[c] : 14'($urandom);
      if (noisy && c >= 1 && $urandom_range(0, 3) == 0) start = 1'b1;
      @(posedge clk);
      c++;
    end
    start = 1'b0;
    check($sformatf("done_cycle[%0d]", code), got_c, exp_c);
    check($sformatf("pass[%0d]", code), pass, exp_pass);
    check($sformatf("fail_mask[%0d]", code), fail_mask, exp_fm);
    check($sformatf("timeout[%0d]", code), timeout, exp_to);
    check($sformatf("unsupported[%0d]", code), unsupported, exp_uns);
    @(negedge clk);
    check("busy_after_done", {busy, done}, 2'b00);
    check("pass_held", pass, exp_pass);
  endtask

  initial begin
    int rd;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {busy, done, pass, fail_mask, timeout, unsupported}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs",
          {busy, done, pass, fail_mask, timeout, unsupported}, 0);

    make_stream(0, 0, -1, 0);       run_check(0, 0);
    make_stream(5, 0, 9, 1'b0);     run_check(5, 0);
    make_stream(6, 0, -1, 0);       run_check(6, 0);
    make_stream(6, 0, 7, 1'b1);     run_check(6, 0);
    make_stream(2, 2, -1, 0);       run_check(2, 0);
    make_stream(9, 3, -1, 0);       run_check(9, 0);
    make_stream(3, 1, -1, 0);       run_check(3, 1);

    for (int t = 0; t < 14; t++) begin
      int code, mode, spin;
      code = (t < 7) ? t : $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      spin = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 13) : -1;
      make_stream(code, mode, spin, 1'($urandom));
      run_check(code, 1);
    end

    make_stream(1, 0, -1, 0);
    @(negedge clk);
    number = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gpio_in = wv[i];
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs",
          {busy, done, pass, fail_mask, timeout, unsupported}, 0);
    rst_n = 1'b1;
    rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) rd++;
    end
    check("no_done_after_reset", rd, 0);
    make_stream(4, 1, -1, 0);       run_check(4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
